day_of_year_counter: RTL and testbench

Sequential calendar counter that replaces the 1–99 digit-pair counter and combinational month/day lookup with one registered block. It advances on each enabled `clk_out` edge and holds three BCD day-of-year digits, a binary month and a two-digit BCD day-of-month, all consistent every cycle. It supports up/down stepping, wrap or saturate at year ends, and a multi-cycle binary load. Its outputs drive the existing dual seven-segment decoders.

---
 rtl/day_of_year_counter.sv | 246 ++++++++++++++++++++++++
 tb/tb_day_of_year_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/day_of_year_counter.sv
// Registered calendar counter: BCD day-of-year, binary month, BCD day-of-month.
// Define LEAP_YEAR_EN to add the leap port (Feb 29, 366-day year).
module day_of_year_counter #(
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_DOY = 1
) (
    input  logic        clk_out,
    input  logic        reset_n,
    input  logic        en,
    input  logic        dir,
    input  logic        load,
    input  logic [8:0]  load_doy,
`ifdef LEAP_YEAR_EN
    input  logic        leap,
`endif
    output logic [11:0] doy_bcd,
    output logic [3:0]  month,
    output logic [7:0]  dom_bcd,
    output logic        wrap,
    output logic        busy
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] SEEK = 1'b1;

    function automatic logic [4:0] mdays(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                    mdays = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: mdays = 5'd30;
            default:                 mdays = 5'd31;
        endcase
    endfunction

    function automatic logic [7:0] bcd2(input logic [4:0] b);
        if (b >= 5'd30)      bcd2 = {4'd3, 4'(b - 5'd30)};
        else if (b >= 5'd20) bcd2 = {4'd2, 4'(b - 5'd20)};
        else if (b >= 5'd10) bcd2 = {4'd1, 4'(b - 5'd10)};
        else                 bcd2 = {4'd0, b[3:0]};
    endfunction

    function automatic logic [11:0] bcd3(input int v);
        bcd3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Elaboration-time month walk for the reset date (non-leap year assumed).
    function automatic logic [3:0] rst_month(input int d);
        int r;
        logic [3:0] m;
        r = d;
        m = 4'd1;
        for (int i = 0; i < 11; i++)
            if (r > int'(mdays(m, 1'b0))) begin
                r = r - int'(mdays(m, 1'b0));
                m = m + 4'd1;
            end
        return m;
    endfunction

    function automatic int rst_rem(input int d);
        int r;
        logic [3:0] m;
        r = d;
        m = 4'd1;
        for (int i = 0; i < 11; i++)
            if (r > int'(mdays(m, 1'b0))) begin
                r = r - int'(mdays(m, 1'b0));
                m = m + 4'd1;
            end
        return r;
    endfunction

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
            else begin
                r[7:4]  = 4'd0;
                r[11:8] = r[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
            else begin
                r[7:4]  = 4'd9;
                r[11:8] = r[11:8] - 4'd1;
            end
        end
        return r;
    endfunction

    // One shift-add-3 iteration; BCD digits live in s[20:9], binary in s[8:0].
    function automatic logic [20:0] dd_step(input logic [20:0] s);
        logic [20:0] t;
        t = s;
        for (int i = 0; i < 3; i++)
            if (t[9+4*i +: 4] >= 4'd5) t[9+4*i +: 4] = t[9+4*i +: 4] + 4'd3;
        return {t[19:0], 1'b0};
    endfunction

    localparam logic [3:0]  RST_MONTH = rst_month(RESET_DOY);
    localparam logic [4:0]  RST_DOM   = 5'(rst_rem(RESET_DOY));
    localparam logic [11:0] RST_DOY   = bcd3(RESET_DOY);

    logic [0:0]  state;
    logic [3:0]  month_q, m, cnt;
    logic [7:0]  dom_q;
    logic [4:0]  dom_bin;
    logic [11:0] doy_q;
    logic        wrap_q;
    logic [8:0]  rem, ld_clamp, ld_ylen;
    logic [20:0] sh;
    logic        lp_eff, lp_ld;

`ifdef LEAP_YEAR_EN
    logic leap_q, init_q;
    // init_q marks the first edge after reset release, where leap is captured.
    assign lp_eff = init_q ? leap : leap_q;
    assign lp_ld  = leap;
    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            leap_q <= 1'b0;
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
            if (init_q || (state == RUN && load)) leap_q <= leap;
        end
    end
`else
    assign lp_eff = 1'b0;
    assign lp_ld  = 1'b0;
`endif

    assign ld_ylen  = lp_ld ? 9'd366 : 9'd365;
    assign ld_clamp = (load_doy == 9'd0)    ? 9'd1    :
                      (load_doy > ld_ylen)  ? ld_ylen : load_doy;

    logic [4:0] md_cur, md_prev, md_seek;
    logic       at_end, at_start;
    assign md_cur   = mdays(month_q, lp_eff);
    assign md_prev  = mdays(month_q - 4'd1, lp_eff);
    assign md_seek  = mdays(m, lp_eff);
    assign at_end   = (month_q == 4'd12) && (dom_bin == 5'd31);
    assign at_start = (month_q == 4'd1) && (dom_bin == 5'd1);

    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            month_q <= RST_MONTH;
            dom_bin <= RST_DOM;
            dom_q   <= bcd2(RST_DOM);
            doy_q   <= RST_DOY;
            wrap_q  <= 1'b0;
            cnt     <= 4'd0;
            rem     <= 9'd0;
            m       <= 4'd1;
            sh      <= 21'd0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                RUN: begin
                    if (load) begin
                        state <= SEEK;
                        cnt   <= 4'd0;
                        rem   <= ld_clamp;
                        m     <= 4'd1;
                        sh    <= {12'd0, ld_clamp};
                    end else if (en && dir) begin
                        if (at_end) begin
                            if (!SATURATE) begin
                                month_q <= 4'd1;
                                dom_bin <= 5'd1;
                                dom_q   <= 8'h01;
                                doy_q   <= 12'h001;
                                wrap_q  <= 1'b1;
                            end
                        end else begin
                            if (dom_bin < md_cur) begin
                                dom_bin <= dom_bin + 5'd1;
                                dom_q   <= bcd2(dom_bin + 5'd1);
                            end else begin
                                dom_bin <= 5'd1;
                                dom_q   <= 8'h01;
                                month_q <= month_q + 4'd1;
                            end
                            doy_q <= bcd_inc(doy_q);
                        end
                    end else if (en) begin
                        if (at_start) begin
                            if (!SATURATE) begin
                                month_q <= 4'd12;
                                dom_bin <= 5'd31;
                                dom_q   <= 8'h31;
                                doy_q   <= lp_eff ? 12'h366 : 12'h365;
                                wrap_q  <= 1'b1;
                            end
                        end else begin
                            if (dom_bin > 5'd1) begin
                                dom_bin <= dom_bin - 5'd1;
                                dom_q   <= bcd2(dom_bin - 5'd1);
                            end else begin
                                month_q <= month_q - 4'd1;
                                dom_bin <= md_prev;
                                dom_q   <= bcd2(md_prev);
                            end
                            doy_q <= bcd_dec(doy_q);
                        end
                    end
                end
                default: begin
                    // Fixed 12-edge seek; month walk needs at most 11, BCD needs 9.
                    cnt <= cnt + 4'd1;
                    if (rem > {4'd0, md_seek}) begin
                        rem <= rem - {4'd0, md_seek};
                        m   <= m + 4'd1;
                    end
                    if (cnt < 4'd9) sh <= dd_step(sh);
                    if (cnt == 4'd11) begin
                        state   <= RUN;
                        month_q <= m;
                        dom_bin <= rem[4:0];
                        dom_q   <= bcd2(rem[4:0]);
                        doy_q   <= sh[20:9];
                    end
                end
            endcase
        end
    end

    assign doy_bcd = doy_q;
    assign month   = month_q;
    assign dom_bcd = dom_q;
    assign wrap    = wrap_q;
    assign busy    = (state == SEEK);

endmodule

// File: tb/tb_day_of_year_counter.sv
// Bench for day_of_year_counter: a wrapping DUT (reset day 1) and a saturating
// DUT (reset day 60) share stimulus and are checked against an integer day model.
module tb_day_of_year_counter;
`ifdef LEAP_YEAR_EN
  localparam bit HAS_LEAP = 1'b1;
  logic leap = 1'b0;
`else
  localparam bit HAS_LEAP = 1'b0;
`endif

  logic clk_out = 1'b0, reset_n = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [8:0] load_doy = 9'd0;
  logic [11:0] doy_a, doy_s;
  logic [3:0] mon_a, mon_s;
  logic [7:0] dom_a, dom_s;
  logic wrap_a, wrap_s, busy_a, busy_s;

  int total = 0, passed = 0;
  int d_a, d_s;
  bit w_a, w_s, bz, m_lp;

  always #5 clk_out = ~clk_out;

  day_of_year_counter #(.SATURATE(1'b0), .RESET_DOY(1)) dut_a (
    .clk_out(clk_out), .reset_n(reset_n), .en(en), .dir(dir), .load(load), .load_doy(load_doy),
`ifdef LEAP_YEAR_EN
    .leap(leap),
`endif
    .doy_bcd(doy_a), .month(mon_a), .dom_bcd(dom_a), .wrap(wrap_a), .busy(busy_a));

  day_of_year_counter #(.SATURATE(1'b1), .RESET_DOY(60)) dut_s (
    .clk_out(clk_out), .reset_n(reset_n), .en(en), .dir(dir), .load(load), .load_doy(load_doy),
`ifdef LEAP_YEAR_EN
    .leap(leap),
`endif
    .doy_bcd(doy_s), .month(mon_s), .dom_bcd(dom_s), .wrap(wrap_s), .busy(busy_s));

  function automatic int ylen(bit lp);
    return lp ? 366 : 365;
  endfunction

  function automatic int bcd(int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Calendar from cumulative month starts rather than a sequential walk.
  function automatic void to_md(int d, bit lp, output int mo, output int dm);
    int cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
    bit found = 1'b0;
    mo = 1;
    dm = d;
    for (int k = 11; k >= 1; k--) begin
      int start = cum[k] + ((lp && k >= 2) ? 1 : 0);
      if (!found && d > start) begin
        found = 1'b1;
        mo = k + 1;
        dm = d - start;
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin passed++; end
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_one(string n, logic [11:0] doy, logic [3:0] mo, logic [7:0] dm,
                           logic w, logic b, int d, bit ew);
    int emo, edm;
    to_md(d, m_lp, emo, edm);
    chk({n, ".doy"},   32'(doy), 32'(bcd(d)));
    chk({n, ".month"}, 32'(mo),  32'(emo));
    chk({n, ".dom"},   32'(dm),  32'(bcd(edm)));
    chk({n, ".wrap"},  32'(w),   32'(ew));
    chk({n, ".busy"},  32'(b),   32'(bz));
  endtask

  task automatic check_all(string tag);
    check_one({tag, ":a"}, doy_a, mon_a, dom_a, wrap_a, busy_a, d_a, w_a);
    check_one({tag, ":s"}, doy_s, mon_s, dom_s, wrap_s, busy_s, d_s, w_s);
  endtask

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic do_step(bit up);
    int y;
    en = 1'b1;
    dir = up;
    tick();
    en = 1'b0;
    y = ylen(m_lp);
    if (up) begin
      if (d_a == y) begin d_a = 1; w_a = 1'b1; end else begin d_a++; w_a = 1'b0; end
      w_s = 1'b0;
      if (d_s != y) d_s++;
    end else begin
      if (d_a == 1) begin d_a = y; w_a = 1'b1; end else begin d_a--; w_a = 1'b0; end
      w_s = 1'b0;
      if (d_s != 1) d_s--;
    end
    check_all(up ? "up" : "down");
  endtask

  task automatic do_idle();
    tick();
    w_a = 1'b0;
    w_s = 1'b0;
    check_all("idle");
  endtask

  task automatic do_load(int v, bit lp, bit noise);
    bit lpe;
    int cv;
    load = 1'b1;
    load_doy = 9'(v);
`ifdef LEAP_YEAR_EN
    leap = lp;
`endif
    tick();
    load = 1'b0;
    bz = 1'b1;
    w_a = 1'b0;
    w_s = 1'b0;
    check_all("load_e0");
    for (int i = 1; i <= 11; i++) begin
      if (noise) begin
        en = 1'($urandom_range(0, 1));
        load = 1'($urandom_range(0, 1));
        dir = 1'($urandom_range(0, 1));
        load_doy = 9'($urandom_range(0, 511));
`ifdef LEAP_YEAR_EN
        leap = 1'($urandom_range(0, 1));
`endif
      end
      tick();
      check_all("seek");
    end
    en = 1'b1;
    load = noise;
    tick();
    en = 1'b0;
    load = 1'b0;
`ifdef LEAP_YEAR_EN
    leap = 1'b0;
`endif
    lpe = HAS_LEAP && lp;
    m_lp = lpe;
    cv = (v < 1) ? 1 : (v > ylen(lpe)) ? ylen(lpe) : v;
    d_a = cv;
    d_s = cv;
    bz = 1'b0;
    check_all("load_e12");
  endtask

  // Called just after an active edge; release lands before the next edge.
  task automatic do_reset();
    en = 1'b0;
    load = 1'b0;
`ifdef LEAP_YEAR_EN
    leap = 1'b0;
`endif
    reset_n = 1'b0;
    #1;
    d_a = 1; d_s = 60; w_a = 1'b0; w_s = 1'b0; bz = 1'b0; m_lp = 1'b0;
    check_all("reset");
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    reset_n = 1'b0;
    #1;
    d_a = 1; d_s = 60; w_a = 1'b0; w_s = 1'b0; bz = 1'b0; m_lp = 1'b0;
    check_all("reset0");
    @(negedge clk_out);
    reset_n = 1'b1;

    repeat (31) do_step(1'b1);             // dut_a: Feb 1 / 032

    do_load(365, 1'b0, 1'b0);
    do_step(1'b1);                         // dut_a wraps, dut_s holds at Dec 31
    do_idle();

    do_reset();
    do_step(1'b0);                         // dut_a: Dec 31 / 365 with wrap
    repeat (265) do_step(1'b0);            // dut_a: Apr 10 / 100

    do_load(60, 1'b0, 1'b0);               // Mar 1
    if (HAS_LEAP) begin
      do_load(60, 1'b1, 1'b0);             // Feb 29
      do_load(400, 1'b1, 1'b0);            // Dec 31 / 366
      do_step(1'b1);
      do_step(1'b0);
    end
    do_load(0, 1'b0, 1'b1);                // Jan 1 / 001, noise during busy
    do_load(400, 1'b0, 1'b1);              // Dec 31 / 365
    do_load(1, 1'b0, 1'b0);
    do_step(1'b0);                         // dut_a wraps down, dut_s holds Jan 1

    load = 1'b1;
    load_doy = 9'd200;
    tick();
    load = 1'b0;
    repeat (4) tick();
    do_reset();                            // abort mid-seek
    do_idle();
    do_step(1'b1);

    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 3)       do_load($urandom_range(0, 511), 1'($urandom_range(0, 1)), 1'b1);
      else if (r < 85) do_step(1'($urandom_range(0, 1)));
      else             do_idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
